// File: rtl/sha256_msg_scheduler.sv
// rtl/sha256_msg_scheduler.sv - SHA-256 message schedule: 16-word sliding window, one shared adder,
// W[t+16] built over three STN-paced cycles and handed straight to the round engine.
`timescale 1ns/1ps
module sha256_msg_scheduler #(
  parameter int WORD_W       = 32,
  parameter int NUM_ROUNDS   = 64,
  parameter int EXPAND_LIMIT = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [3:0]        load_addr,
  input  logic [WORD_W-1:0] load_data,
  input  logic              start,
  input  logic              stn,
  output logic [WORD_W-1:0] wt_out,
  output logic [5:0]        round_idx,
  output logic              busy,
  output logic              sched_done,
  output logic              overrun
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
  localparam logic [5:0] EXP_LIM    = 6'(EXPAND_LIMIT);

  typedef enum logic [2:0] {IDLE, READY, ADD0, ADD1, ADD2, DONE} state_t;

  state_t            state, next_state;
  logic [WORD_W-1:0] window [16];
  logic [WORD_W-1:0] acc;
  logic              stn_q;
  logic              stn_fall;
  logic              load_ok, clear_round, shift, acc_we, set_ovr;
  logic [WORD_W-1:0] add_a, add_b, add_sum;

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign stn_fall = stn_q & ~stn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    load_ok     = 1'b0;
    clear_round = 1'b0;
    shift       = 1'b0;
    acc_we      = 1'b0;
    set_ovr     = 1'b0;
    case (state)
      IDLE, DONE: begin
        load_ok = 1'b1;
        if (start) begin
          next_state  = READY;
          clear_round = 1'b1;
        end
      end
      READY: begin
        if (stn_fall) next_state = (round_idx == LAST_ROUND) ? DONE : ADD0;
      end
      ADD0: begin
        acc_we     = 1'b1;
        set_ovr    = stn_fall;
        next_state = ADD1;
      end
      ADD1: begin
        acc_we     = 1'b1;
        set_ovr    = stn_fall;
        next_state = ADD2;
      end
      ADD2: begin
        shift      = 1'b1;
        set_ovr    = stn_fall;
        next_state = READY;
      end
      default: next_state = IDLE;
    endcase
  end

  // The single adder: sigma1(W[t+14])+W[t+9], then +sigma0(W[t+1]), then +W[t].
  always_comb begin
    add_a = acc;
    add_b = window[0];
    case (state)
      ADD0: begin
        add_a = sig1(window[14]);
        add_b = window[9];
      end
      ADD1: add_b = sig0(window[1]);
      default: ;
    endcase
  end

  assign add_sum = add_a + add_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) window[i] <= '0;
      acc       <= '0;
      stn_q     <= 1'b0;
      round_idx <= '0;
      overrun   <= 1'b0;
    end else begin
      stn_q <= stn;
      if (acc_we) acc <= add_sum;
      if (load_ok && load_en) window[load_addr] <= load_data;
      if (shift) begin
        for (int i = 0; i < 15; i++) window[i] <= window[i+1];
        // Words past W63 are never consumed, so the tail is zero-filled.
        window[15] <= (round_idx < EXP_LIM) ? add_sum : '0;
        round_idx  <= round_idx + 6'd1;
      end
      if (clear_round) begin
        round_idx <= '0;
        overrun   <= 1'b0;
      end else if (set_ovr) begin
        overrun <= 1'b1;
      end
    end
  end

  assign wt_out     = window[0];
  assign busy       = (state == ADD0) || (state == ADD1) || (state == ADD2);
  assign sched_done = (state == DONE);

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// tb/tb_sha256_msg_scheduler.sv - self-checking bench for sha256_msg_scheduler
`timescale 1ns/1ps
module tb_sha256_msg_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic        stn = 1'b1;
  logic [31:0] wt_out;
  logic [5:0]  round_idx;
  logic        busy;
  logic        sched_done;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_w [64];
  logic [31:0] exp_q [$];
  logic [5:0]  exp_r_q [$];
  int          model_round = 0;
  logic [31:0] k_abc [4] = '{32'h61626380, 32'h000f0000, 32'h7da86405, 32'h600003c6};

  sha256_msg_scheduler dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stn(stn), .wt_out(wt_out), .round_idx(round_idx), .busy(busy),
    .sched_done(sched_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_ref();
    for (int t = 16; t < 64; t++)
      ref_w[t] = s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) ref_w[i] = '0;
    ref_w[0]  = 32'h61626380;
    ref_w[15] = 32'h00000018;
    build_ref();
  endtask

  task automatic load_block(input bit with_start);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = 4'(i);
      load_data = ref_w[i];
      start     = with_start && (i == 15);
    end
    @(negedge clk);
    load_en = 1'b0;
    start   = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // lat counts posedges from the one that registers the falling edge until busy drops.
  task automatic pulse_stn(output int lat);
    @(negedge clk) stn = 1'b0;
    @(negedge clk) stn = 1'b1;
    lat = 1;
    while (busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic step_round();
    int          lat;
    int          exp_lat;
    logic [31:0] ew;
    logic [5:0]  er;
    if (model_round < 63) begin
      model_round++;
      exp_lat = 4;
    end else begin
      exp_lat = 1;
    end
    exp_q.push_back(ref_w[model_round]);
    exp_r_q.push_back(6'(model_round));
    pulse_stn(lat);
    ew = exp_q.pop_front();
    er = exp_r_q.pop_front();
    checks++;
    if (wt_out !== ew) begin
      errors++;
      $display("FAIL wt_round%0d: wt_out=%h expected %h", model_round, wt_out, ew);
    end
    checks++;
    if (round_idx !== er) begin
      errors++;
      $display("FAIL round_idx_round%0d: round_idx=%0d expected %0d", model_round, round_idx, er);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL latency_round%0d: clocks=%0d expected %0d", model_round, lat, exp_lat);
    end
    if (lat < 8) repeat (8 - lat) @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({wt_out, round_idx, busy, sched_done, overrun} !== 41'd0) begin
      errors++;
      $display("FAIL reset_por: outputs=%h expected 0", {wt_out, round_idx, busy, sched_done, overrun});
    end
    @(negedge clk) rst = 1'b0;
    set_abc();
    load_block(1'b1);
    @(negedge clk) stn = 1'b0;
    @(negedge clk) stn = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || wt_out !== 32'h61626380) begin
      errors++;
      $display("FAIL reset_pre_add1: busy=%b wt_out=%h expected 1 61626380", busy, wt_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wt_out, round_idx, busy, sched_done, overrun} !== 41'd0) begin
      errors++;
      $display("FAIL reset_mid_add: outputs=%h expected 0", {wt_out, round_idx, busy, sched_done, overrun});
    end
    @(negedge clk) rst = 1'b0;
    do_start();
    checks++;
    if (wt_out !== 32'd0 || round_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_block_lost: wt_out=%h round_idx=%0d expected 0 0", wt_out, round_idx);
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_abc_load();
    set_abc();
    load_block(1'b0);
    do_start();
    model_round = 0;
    checks++;
    if (wt_out !== 32'h61626380 || round_idx !== 6'd0) begin
      errors++;
      $display("FAIL abc_w0: wt_out=%h round_idx=%0d expected 61626380 0", wt_out, round_idx);
    end
    checks++;
    if (busy !== 1'b0 || sched_done !== 1'b0) begin
      errors++;
      $display("FAIL abc_flags: busy=%b sched_done=%b expected 0 0", busy, sched_done);
    end
  endtask

  task automatic test_expansion();
    for (int i = 1; i <= 19; i++) begin
      step_round();
      if (i >= 16) begin
        checks++;
        if (wt_out !== k_abc[i-16]) begin
          errors++;
          $display("FAIL abc_w%0d: wt_out=%h expected %h", i, wt_out, k_abc[i-16]);
        end
      end
    end
  endtask

  task automatic test_full_block();
    logic [31:0] w63;
    for (int i = 20; i <= 63; i++) step_round();
    w63 = ref_w[63];
    checks++;
    if (round_idx !== 6'd63 || wt_out !== w63 || sched_done !== 1'b0) begin
      errors++;
      $display("FAIL full_w63: round_idx=%0d wt_out=%h done=%b expected 63 %h 0", round_idx, wt_out, sched_done, w63);
    end
    step_round();
    checks++;
    if (sched_done !== 1'b1 || busy !== 1'b0 || wt_out !== w63) begin
      errors++;
      $display("FAIL full_done: done=%b busy=%b wt_out=%h expected 1 0 %h", sched_done, busy, wt_out, w63);
    end
  endtask

  task automatic test_load_gating();
    for (int i = 0; i < 16; i++) ref_w[i] = $urandom;
    build_ref();
    load_block(1'b1);
    model_round = 0;
    checks++;
    if (wt_out !== ref_w[0] || round_idx !== 6'd0 || sched_done !== 1'b0) begin
      errors++;
      $display("FAIL gate_done_load: wt_out=%h round_idx=%0d done=%b expected %h 0 0", wt_out, round_idx, sched_done, ref_w[0]);
    end
    @(negedge clk);
    load_en = 1'b1; load_addr = 4'd0; load_data = ~ref_w[0];
    repeat (2) @(negedge clk);
    load_en = 1'b0;
    checks++;
    if (wt_out !== ref_w[0]) begin
      errors++;
      $display("FAIL gate_ready_load: wt_out=%h expected %h", wt_out, ref_w[0]);
    end
    load_en = 1'b1; load_addr = 4'd1; load_data = 32'hdeadbeef ^ ref_w[1];
    step_round();
    step_round();
    load_en = 1'b0;
    do_start();
    checks++;
    if (round_idx !== 6'd2 || wt_out !== ref_w[2]) begin
      errors++;
      $display("FAIL gate_start_ready: round_idx=%0d wt_out=%h expected 2 %h", round_idx, wt_out, ref_w[2]);
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_initial: overrun=%b expected 0", overrun);
    end
    @(negedge clk) stn = 1'b0;
    @(negedge clk) stn = 1'b1;
    @(negedge clk) stn = 1'b0;
    @(negedge clk) stn = 1'b1;
    repeat (8) @(negedge clk);
    model_round++;
    checks++;
    if (overrun !== 1'b1 || round_idx !== 6'(model_round) || wt_out !== ref_w[model_round]) begin
      errors++;
      $display("FAIL ovr_double: overrun=%b round_idx=%0d wt_out=%h expected 1 %0d %h",
               overrun, round_idx, wt_out, model_round, ref_w[model_round]);
    end
    while (model_round < 63) step_round();
    step_round();
    checks++;
    if (overrun !== 1'b1 || sched_done !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: overrun=%b done=%b expected 1 1", overrun, sched_done);
    end
    do_start();
    model_round = 0;
    checks++;
    if (overrun !== 1'b0 || round_idx !== 6'd0 || sched_done !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: overrun=%b round_idx=%0d done=%b expected 0 0 0", overrun, round_idx, sched_done);
    end
  endtask

  initial begin
    test_reset();
    test_abc_load();
    test_expansion();
    test_full_block();
    test_load_gating();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_scheduler.md
Name: sha256_msg_scheduler

Overview:
Upstream neighbour of the SHA-256 round engine. It holds one 512-bit message block as a 16-word sliding window and presents W[t] on wt_out for round t. It computes W[t+16] with a single shared 32-bit adder, paced by the round engine's STN strobe. The result is handed straight to the engine's Wt_in with no extra buffering.

Parameters:
WORD_W, 32, word width; fixed at 32 for SHA-256, not to be overridden.
NUM_ROUNDS, 64, total rounds per block; sets the round_idx terminal value (NUM_ROUNDS-1).
EXPAND_LIMIT, 48, number of rounds for which a new word is computed; rounds at or above this shift in zero.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
load_en  in  1  write load_data into window[load_addr]; honoured only in IDLE or DONE
load_addr  in  4  word index; 0 = most-significant word of the block (W0)
load_data  in  32  message word
start  in  1  single-cycle pulse; begin the schedule for the loaded block
stn  in  1  STN from the round engine; a falling edge means W[t] has been consumed
wt_out  out  32  current W[t] (= window[0])
round_idx  out  6  index t of the word currently on wt_out
busy  out  1  high in ADD0/ADD1/ADD2
sched_done  out  1  high in DONE
overrun  out  1  sticky: an stn falling edge arrived while busy

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE, window[0..15]=0, acc=0, stn_q=0, round_idx=0;
  - wt_out=0, busy=0, sched_done=0, overrun=0.
- stn_q is a register copy of stn. stn_fall = stn_q & ~stn.
- States: IDLE, READY, ADD0, ADD1, ADD2, DONE.
- IDLE and DONE:
  - load_en writes window[load_addr] in the same edge;
  - start -> READY, round_idx<=0, overrun<=0;
  - if start and load_en occur together, the load is performed and start is also taken.
- READY:
  - stn_fall and round_idx<63 -> ADD0;
  - stn_fall and round_idx==63 -> DONE (no shift);
  - load_en and start are ignored.
- ADD0: acc <= sigma1(window[14]) + window[9].
- ADD1: acc <= acc + sigma0(window[1]).
- ADD2:
  - window[i] <= window[i+1] for i=0..14;
  - window[15] <= (round_idx+16 < 64) ? acc + window[0] : 0, i.e. zero when round_idx >= 48;
  - round_idx <= round_idx+1; next state READY.
- Functions:
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3;
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10;
  - all additions are mod 2^32 (carry discarded);
  - exactly one 32-bit adder is instantiated, with its operands muxed by state.
- Timing contract:
  - the falling edge is seen in the engine's UPDATE cycle;
  - ADD0, ADD1 and ADD2 coincide with engine STEP1, STEP2 and STEP3;
  - the new wt_out is stable from engine STEP4 (the Wt_in read cycle).
  - Latency from stn_fall to new wt_out is 3 clocks.
- wt_out for round 0 is valid from the cycle after start.
- stn_fall during ADD0/ADD1/ADD2: the edge is dropped, overrun<=1 (sticky until the next start), and the computation continues undisturbed.
- stn rising edges and a steady stn level have no effect.
- start while not in IDLE or DONE: ignored.
- Reset asserted mid-ADD: immediate return to the reset values; the loaded block is lost.

Test Plan:
- Reset:
  - stimulus: assert rst asynchronously mid-ADD1;
  - response: outputs go to zero before the next edge; state=IDLE; wt_out=0.
- "abc" block:
  - stimulus: load W0=0x61626380, W1..W14=0, W15=0x00000018; pulse start;
  - response: wt_out=0x61626380, round_idx=0.
- Expansion through W19 (stimulus: apply 16 stn falling edges spaced 8 clocks apart):
  - after each edge, wt_out equals the loaded W1..W15 in turn, and round_idx advances to 16;
  - on further edges, wt_out reads 0x61626380, 0x000f0000, 0x7da86405, 0x600003c6 at rounds 16..19;
  - each update lands exactly 3 clocks after the edge.
- Full block:
  - stimulus: 63 edges;
  - response: round_idx=63, and wt_out equals the reference W63.
  - stimulus: the 64th edge;
  - response: sched_done=1 and wt_out unchanged.
- Overrun:
  - stimulus: a second stn falling edge 1 clock after the first;
  - response: overrun=1, round_idx advances by exactly 1, and the next start clears overrun.
- Load gating:
  - stimulus: load_en while READY or busy;
  - response: window unchanged.
  - stimulus: a load in DONE followed by start;
  - response: the new block's W0 appears on wt_out.
